// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, default RAM depth
// and byte-lane constants.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam int         LOADER_DEPTH = 256;
   localparam int         BYTE_W       = 8;
   localparam logic [1:0] LANE_FIRST   = 2'd0;
   localparam logic [1:0] LANE_LAST    = 2'd3;

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian bytes into a 32-bit word; word/commit are combinational
// on the accepted byte, never stalls (consumes whenever load is high).
module word_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [BYTE_W-1:0] in_byte,
   input  logic              in_last,
   output logic              commit,
   output logic [31:0]       word
);

   logic [1:0]  lane;
   logic [31:0] acc;

   // Unwritten upper lanes are still zero in acc, so a short final word
   // comes out zero-padded without extra masking.
   always_comb begin
      word = acc;
      word[{lane, 3'b000} +: BYTE_W] = in_byte;
      commit = load & ((lane == LANE_LAST) | in_last);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc  <= '0;
         lane <= LANE_FIRST;
      end else if (clear || commit) begin
         acc  <= '0;
         lane <= LANE_FIRST;
      end else if (load) begin
         acc  <= word;
         lane <= lane + 2'd1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into instruction RAM, holding the CPU in reset until done.
// Write lands one cycle after the completing byte; in_ready is high only in LOAD.
module program_loader
   import loader_pkg::*;
#(
   parameter int DEPTH  = LOADER_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_byte,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   state_t      state, state_nxt;
   logic        xfer, overflow, asm_load, honour_start, commit;
   logic [31:0] asm_word;

   assign in_ready     = (state == ST_LOAD);
   assign xfer         = in_valid & in_ready;
   assign overflow     = xfer && (word_count == (ADDR_W+1)'(DEPTH));
   assign asm_load     = xfer & ~overflow;
   assign honour_start = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR));

   word_assembler u_asm (
      .clk     (clk),
      .reset   (reset),
      .clear   (honour_start),
      .load    (asm_load),
      .in_byte (in_byte),
      .in_last (in_last),
      .commit  (commit),
      .word    (asm_word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (overflow)            state_nxt = ST_ERR;
            else if (xfer & in_last) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // word_count doubles as the word address; its low bits never wrap because
   // any byte arriving at word_count==DEPTH is dropped into ERR.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (honour_start) begin
            mem_we     <= 1'b0;
            word_count <= '0;
         end else if (commit) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_W-1:0];
            mem_wdata  <= asm_word;
            word_count <= word_count + 1'b1;
         end else begin
            mem_we <= 1'b0;
         end
         cpu_reset <= (state_nxt != ST_DONE);
         done      <= (state_nxt == ST_DONE);
         error     <= (state_nxt == ST_ERR);
      end
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the instruction-RAM depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the word-address width, equal to clog2(DEPTH).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named clk and reset as elsewhere in the codebase.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a new load; honoured only in IDLE, DONE and ERR.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_byte  input  8  program byte; words are little-endian, first byte goes to bits [7:0].
REQ-009 in_last  input  1  marks the final byte of the program; qualified by in_valid.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  instruction-RAM write strobe, one cycle per word.
REQ-012 mem_addr  output  ADDR_W  word address of the write.
REQ-013 mem_wdata  output  32  assembled instruction word.
REQ-014 cpu_reset  output  1  active-high hold for the CPU core; deasserted only in DONE.
REQ-015 done  output  1  program fully written.
REQ-016 error  output  1  program overflowed DEPTH.
REQ-017 word_count  output  ADDR_W+1  number of words written in the current load.

Function
REQ-018 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; bytes offered while in_ready=0 SHALL be ignored.
REQ-019 States SHALL be IDLE, LOAD, FLUSH, DONE and ERR.
REQ-020 Transitions on start SHALL be: IDLE, DONE or ERR go to LOAD, clearing byte lane, word address, word_count, done and error.
REQ-021 start in LOAD or FLUSH SHALL be ignored.
REQ-022 in_ready SHALL equal 1 only in LOAD.
REQ-023 Byte lane SHALL be a 2-bit counter: lane 0 to bits [7:0], 1 to [15:8], 2 to [23:16], 3 to [31:24]; it SHALL wrap 3 to 0 on a word commit.
REQ-024 A word SHALL commit on the transfer of lane 3, or on any transfer with in_last=1.
REQ-025 On commit, mem_we SHALL be 1 for exactly the next cycle, with mem_addr equal to the current word address and mem_wdata equal to the assembled word.
REQ-026 Lanes not yet written when in_last arrives SHALL be zero in mem_wdata.
REQ-027 After each commit, word address and word_count SHALL increment; word_count becomes visible in the same cycle as mem_we.
REQ-028 A transfer with in_last=1 SHALL move LOAD to FLUSH; FLUSH lasts exactly one cycle (the mem_we cycle) and then moves to DONE.
REQ-029 Back-to-back words SHALL sustain one byte per cycle with no stall; mem_we of word N may coincide with accepting a byte of word N+1.
REQ-030 Overflow: a transfer accepted while word_count==DEPTH SHALL be dropped (no mem_we), the state SHALL move to ERR, and error SHALL be 1 from the next cycle.
REQ-031 Exactly DEPTH words ending with in_last SHALL go to DONE, not ERR.
REQ-032 Word address SHALL NOT wrap into previously written words.
REQ-033 cpu_reset SHALL be 0 only in DONE and SHALL reassert in the cycle after start is honoured in DONE.
REQ-034 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-035 All outputs SHALL be registered, except in_ready, which is decoded from state.

Reset
REQ-036 Assertion of reset (low) SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0 and lane=0.
REQ-037 Reset mid-load SHALL discard any partially assembled word without a write.
REQ-038 After reset release, no mem_we SHALL occur before the next honoured start.

Structure
REQ-039 The state encoding, DEPTH default and the byte-lane constants SHALL live in a shared package, loader_pkg.
REQ-040 One sub-module, word_assembler (byte-lane counter plus 32-bit shift/merge register), SHALL be used; the FSM stays in program_loader.

Verification
REQ-041 start, then bytes 37,01,06,00 | B7,41,00,00 (last) -> mem_we at addr 0 with 0x00060137, then addr 1 with 0x000041B7; done=1; cpu_reset=0; word_count=2.
REQ-042 start, then 3 bytes AA,BB,CC with in_last on CC -> one write to addr 0 with 0x00CCBBAA, FLUSH then DONE.
REQ-043 DEPTH=4, 16 bytes with in_last on byte 16 -> 4 writes to addr 0..3, DONE; then 17 bytes without in_last -> 17th byte dropped, ERR, error=1, cpu_reset=1.
REQ-044 Continuous in_valid for 8 bytes -> in_ready held 1 throughout, mem_we on cycles 5 and 9 after the first transfer, no gaps.
REQ-045 Reset low after 2 bytes, then high, then start, then 4 bytes 11,22,33,44 -> single write 0x44332211 to addr 0.
REQ-046 start while in LOAD, and in_valid while in IDLE or DONE -> no state change and no mem_we.
